// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the DAC SPI frame sequencer.
package dac_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP,
        ST_LDAC,
        ST_DONE
    } state_e;

    localparam logic [3:0] CMD_DAC_A = 4'b0011;
    localparam logic [3:0] CMD_DAC_B = 4'b1011;

endpackage

// File: rtl/spi_tick_gen.sv
// Divides clk into ticks; one tick marks one SCLK half-period.
module spi_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = enable && (cnt_q == CW'(CLK_DIV - 1));
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dac_spi_seq.sv
// Sends one {cmd,data} SPI frame per DAC channel, then pulses LDAC.
module dac_spi_seq
    import dac_spi_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int DATA_W      = 12,
    parameter int CMD_W       = 4,
    parameter int CLK_DIV     = 2,
    parameter int LDAC_TICKS  = 1,
    parameter int AUTO_PERIOD = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic [NUM_CH*CMD_W-1:0]  cmd_in,
    output logic                     sclk,
    output logic                     cs_n,
    output logic                     sdi,
    output logic                     ldac,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);

    localparam int FRAME_W = CMD_W + DATA_W;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LD_W    = (LDAC_TICKS > 1) ? $clog2(LDAC_TICKS) : 1;

    state_e               state_q, state_d;
    logic [CH_W-1:0]      ch_q, ch_d, nxt_ch;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [LD_W-1:0]      ld_q, ld_d;
    logic [FRAME_W-1:0]   sr_q, sr_d;
    logic [FRAME_W-1:0]   words_q [NUM_CH];
    logic [FRAME_W-1:0]   words_d [NUM_CH];
    logic sclk_q, sclk_d, cs_n_q, cs_n_d, sdi_q, sdi_d;
    logic ldac_q, ldac_d, busy_q, busy_d;
    logic done_q, done_d, ovr_q, ovr_d;
    logic trig, accept, auto_trig;
    logic tick, tick_clr, tick_en;

    generate
        if (AUTO_PERIOD > 0) begin : g_auto
            localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
            logic [AW-1:0] auto_q, auto_d;
            always_comb begin
                auto_trig = (auto_q == AW'(AUTO_PERIOD - 1));
                auto_d    = auto_trig ? '0 : auto_q + 1'b1;
            end
            always_ff @(posedge clk) begin
                if (rst) auto_q <= '0;
                else     auto_q <= auto_d;
            end
        end else begin : g_no_auto
            assign auto_trig = 1'b0;
        end
    endgenerate

    spi_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (tick_clr),
        .enable(tick_en),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        bit_d    = bit_q;
        ld_d     = ld_q;
        sr_d     = sr_q;
        words_d  = words_q;
        sclk_d   = sclk_q;
        cs_n_d   = cs_n_q;
        sdi_d    = sdi_q;
        ldac_d   = ldac_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ovr_d    = ovr_q;
        nxt_ch   = ch_q + 1'b1;
        trig     = start | auto_trig;
        accept   = trig && (state_q == ST_IDLE || state_q == ST_DONE);
        tick_clr = accept;
        tick_en  = (state_q == ST_SHIFT) || (state_q == ST_GAP) ||
                   (state_q == ST_LDAC);
        if (trig && !accept) ovr_d = 1'b1;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        words_d[i] = {cmd_in[i*CMD_W +: CMD_W],
                                      data_in[i*DATA_W +: DATA_W]};
                    end
                    state_d = ST_SHIFT;
                    ch_d    = '0;
                    bit_d   = '0;
                    ld_d    = '0;
                    sr_d    = words_d[0];
                    sdi_d   = words_d[0][FRAME_W-1];
                    sclk_d  = 1'b0;
                    cs_n_d  = 1'b0;
                    ldac_d  = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (tick && !sclk_q) begin
                    sclk_d = 1'b1;
                end else if (tick) begin
                    // Falling edge: present the next bit or close the frame
                    sclk_d = 1'b0;
                    if (bit_q == BIT_W'(FRAME_W - 1)) begin
                        state_d = ST_GAP;
                        cs_n_d  = 1'b1;
                        sdi_d   = 1'b0;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        sr_d  = sr_q << 1;
                        sdi_d = sr_q[FRAME_W-2];
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (ch_q != CH_W'(NUM_CH - 1)) begin
                        state_d = ST_SHIFT;
                        ch_d    = nxt_ch;
                        cs_n_d  = 1'b0;
                        sr_d    = words_q[nxt_ch];
                        sdi_d   = words_q[nxt_ch][FRAME_W-1];
                    end else if (LDAC_TICKS == 0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_LDAC;
                        ldac_d  = 1'b1;
                        ld_d    = '0;
                    end
                end
            end
            ST_LDAC: begin
                if (tick) begin
                    if (ld_q == LD_W'(LDAC_TICKS - 1)) begin
                        state_d = ST_DONE;
                        ldac_d  = 1'b0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        ld_d = ld_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            bit_q   <= '0;
            ld_q    <= '0;
            sr_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) words_q[i] <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            sdi_q   <= 1'b0;
            ldac_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            bit_q   <= bit_d;
            ld_q    <= ld_d;
            sr_q    <= sr_d;
            words_q <= words_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            sdi_q   <= sdi_d;
            ldac_q  <= ldac_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign sclk    = sclk_q;
    assign cs_n    = cs_n_q;
    assign sdi     = sdi_q;
    assign ldac    = ldac_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_dac_spi_seq.sv
// Randomised self-checking bench for dac_spi_seq in three configurations.
module tb_dac_spi_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int passed = 0;
    int total  = 0;

    // a: defaults, f: 4ch CLK_DIV=1 no LDAC, t: auto-triggered every 200
    logic        rst_a = 1'b1, start_a = 1'b0;
    logic [23:0] data_a = '0;
    logic [7:0]  cmd_a = '0;
    logic sclk_a, cs_a, sdi_a, ldac_a, busy_a, done_a, ovr_a;
    logic        rst_f = 1'b1, start_f = 1'b0;
    logic [47:0] data_f = '0;
    logic [15:0] cmd_f = '0;
    logic sclk_f, cs_f, sdi_f, ldac_f, busy_f, done_f, ovr_f;
    logic        rst_t = 1'b1, start_t = 1'b0;
    logic [23:0] data_t = '0;
    logic [7:0]  cmd_t = '0;
    logic sclk_t, cs_t, sdi_t, ldac_t, busy_t, done_t, ovr_t;

    dac_spi_seq u_dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .data_in(data_a),
        .cmd_in(cmd_a), .sclk(sclk_a), .cs_n(cs_a), .sdi(sdi_a),
        .ldac(ldac_a), .busy(busy_a), .done(done_a), .overrun(ovr_a));

    dac_spi_seq #(.NUM_CH(4), .CLK_DIV(1), .LDAC_TICKS(0)) u_dut_f (
        .clk(clk), .rst(rst_f), .start(start_f), .data_in(data_f),
        .cmd_in(cmd_f), .sclk(sclk_f), .cs_n(cs_f), .sdi(sdi_f),
        .ldac(ldac_f), .busy(busy_f), .done(done_f), .overrun(ovr_f));

    dac_spi_seq #(.AUTO_PERIOD(200)) u_dut_t (
        .clk(clk), .rst(rst_t), .start(start_t), .data_in(data_t),
        .cmd_in(cmd_t), .sclk(sclk_t), .cs_n(cs_t), .sdi(sdi_t),
        .ldac(ldac_t), .busy(busy_t), .done(done_t), .overrun(ovr_t));

    logic [2:0] rst_v, sclk_v, cs_v, sdi_v, ldac_v, done_v;
    assign rst_v  = {rst_t, rst_f, rst_a};
    assign sclk_v = {sclk_t, sclk_f, sclk_a};
    assign cs_v   = {cs_t, cs_f, cs_a};
    assign sdi_v  = {sdi_t, sdi_f, sdi_a};
    assign ldac_v = {ldac_t, ldac_f, ldac_a};
    assign done_v = {done_t, done_f, done_a};

    // Bus monitor: what a DAC would capture on each sclk rising edge
    logic [23:0] q0[$], q1[$], q2[$];
    logic [15:0] word [3];
    int nb [3];
    int viol [3];
    int ldac_n [3];
    logic [2:0] sclk_l = '0, cs_l = '1, sdi_l = '0;

    initial begin
        for (int d = 0; d < 3; d++) begin
            word[d] = '0; nb[d] = 0; viol[d] = 0; ldac_n[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (rst_v[d]) begin
                    word[d] = '0;
                    nb[d] = 0;
                end else begin
                    if (!cs_v[d] && !cs_l[d] && sdi_v[d] !== sdi_l[d] &&
                        !(sclk_l[d] && !sclk_v[d])) viol[d]++;
                    if (cs_v[d] && sclk_v[d]) viol[d]++;
                    if (!cs_v[d] && sclk_v[d] && !sclk_l[d]) begin
                        word[d] = {word[d][14:0], sdi_v[d]};
                        nb[d]++;
                    end
                    if (cs_v[d] && !cs_l[d]) begin
                        case (d)
                            0: q0.push_back({8'(nb[d]), word[d]});
                            1: q1.push_back({8'(nb[d]), word[d]});
                            default: q2.push_back({8'(nb[d]), word[d]});
                        endcase
                        word[d] = '0;
                        nb[d] = 0;
                    end
                    if (ldac_v[d]) ldac_n[d]++;
                end
                sclk_l[d] = sclk_v[d];
                cs_l[d]   = cs_v[d];
                sdi_l[d]  = sdi_v[d];
            end
        end
    end

    // Expected frame for channel ch: its command nibble above its 12-bit code
    function automatic logic [15:0] exp_word(input logic [47:0] data,
                                             input logic [15:0] cmd,
                                             input int ch);
        logic [47:0] ds;
        logic [15:0] cs;
        ds = data >> (12 * ch);
        cs = cmd >> (4 * ch);
        return {cs[3:0], ds[11:0]};
    endfunction

    function automatic int qsize(input int d);
        case (d)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic pop_word(input int d, output logic [15:0] w,
                            output int n);
        logic [23:0] e;
        e = '0;
        case (d)
            0: if (q0.size() > 0) e = q0.pop_front();
            1: if (q1.size() > 0) e = q1.pop_front();
            default: if (q2.size() > 0) e = q2.pop_front();
        endcase
        w = e[15:0];
        n = int'(e[23:16]);
    endtask

    task automatic run_grp(input int d, input logic [47:0] data,
                           input logic [15:0] cmd, output int lat,
                           output bit ok, output bit b1);
        int t0;
        @(negedge clk);
        if (d == 0) begin
            data_a = data[23:0]; cmd_a = cmd[7:0]; start_a = 1'b1;
        end else begin
            data_f = data; cmd_f = cmd; start_f = 1'b1;
        end
        t0 = cyc;
        @(negedge clk);
        start_a = 1'b0;
        start_f = 1'b0;
        b1 = (d == 0) ? (busy_a && !cs_a) : (busy_f && !cs_f);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done_v[d]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        lat = cyc - t0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_f = 1'b0;
        @(negedge clk);
        total++; if (sclk_a !== 1'b0) $display("FAIL rst_sclk got %b want 0", sclk_a); else passed++;
        total++; if (cs_a !== 1'b1) $display("FAIL rst_cs_n got %b want 1", cs_a); else passed++;
        total++; if (sdi_a !== 1'b0) $display("FAIL rst_sdi got %b want 0", sdi_a); else passed++;
        total++; if (ldac_a !== 1'b0) $display("FAIL rst_ldac got %b want 0", ldac_a); else passed++;
        total++; if (busy_a !== 1'b0) $display("FAIL rst_busy got %b want 0", busy_a); else passed++;
        total++; if (done_a !== 1'b0) $display("FAIL rst_done got %b want 0", done_a); else passed++;
        total++; if (ovr_a !== 1'b0) $display("FAIL rst_overrun got %b want 0", ovr_a); else passed++;
        total++; if ({cs_f, busy_f} !== 2'b10) $display("FAIL rst_fast got %b want 10", {cs_f, busy_f}); else passed++;
    endtask

    task automatic test_frame();
        logic [47:0] d;
        logic [15:0] c, w;
        int lat, n;
        bit ok, b1;
        for (int k = 0; k < 4; k++) begin
            d = (k == 0) ? 48'h0AB123 : {24'h0, 24'($urandom)};
            c = (k == 0) ? 16'h00B3 : {8'h0, 8'($urandom)};
            ldac_n[0] = 0;
            run_grp(0, d, c, lat, ok, b1);
            total++; if (!ok) $display("FAIL frame_timeout k=%0d no done in 2000 cycles", k); else passed++;
            total++; if (lat !== 135) $display("FAIL frame_latency got %0d want 135", lat); else passed++;
            total++; if (b1 !== 1'b1) $display("FAIL frame_entry busy/cs got %b want 1", b1); else passed++;
            total++; if (busy_a !== 1'b0) $display("FAIL frame_done_busy got %b want 0", busy_a); else passed++;
            total++; if (ldac_n[0] !== 2) $display("FAIL frame_ldac_cycles got %0d want 2", ldac_n[0]); else passed++;
            total++; if (qsize(0) !== 2) $display("FAIL frame_count got %0d want 2", qsize(0)); else passed++;
            for (int ch = 0; ch < 2; ch++) begin
                pop_word(0, w, n);
                total++; if (w !== exp_word(d, c, ch) || n !== 16) $display("FAIL frame_word ch%0d got %h/%0d want %h/16", ch, w, n, exp_word(d, c, ch)); else passed++;
            end
            @(negedge clk);
            total++; if (done_a !== 1'b0) $display("FAIL frame_done_pulse got %b want 0", done_a); else passed++;
        end
    endtask

    task automatic test_overrun();
        logic [47:0] d;
        logic [15:0] c, w;
        int t0, lat, n;
        bit ok;
        d = {24'h0, 24'($urandom)};
        c = {8'h0, 8'($urandom)};
        @(negedge clk);
        data_a = d[23:0]; cmd_a = c[7:0]; start_a = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_a = 1'b0;
        repeat (9) @(negedge clk);
        total++; if (ovr_a !== 1'b0) $display("FAIL ovr_before got %b want 0", ovr_a); else passed++;
        data_a = ~d[23:0];
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        total++; if (ovr_a !== 1'b1) $display("FAIL ovr_set got %b want 1", ovr_a); else passed++;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done_a) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        lat = cyc - t0;
        total++; if (!ok || lat !== 135) $display("FAIL ovr_latency got %0d want 135", lat); else passed++;
        total++; if (ovr_a !== 1'b1) $display("FAIL ovr_sticky got %b want 1", ovr_a); else passed++;
        total++; if (qsize(0) !== 2) $display("FAIL ovr_count got %0d want 2", qsize(0)); else passed++;
        for (int ch = 0; ch < 2; ch++) begin
            pop_word(0, w, n);
            total++; if (w !== exp_word(d, c, ch)) $display("FAIL ovr_word ch%0d got %h want %h", ch, w, exp_word(d, c, ch)); else passed++;
        end
        repeat (3) @(negedge clk);
        total++; if (ovr_a !== 1'b1) $display("FAIL ovr_idle_sticky got %b want 1", ovr_a); else passed++;
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        total++; if (ovr_a !== 1'b0) $display("FAIL ovr_clear got %b want 0", ovr_a); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [47:0] d;
        logic [15:0] c, w;
        int t0, cs_hi, nd, n;
        int dc [3];
        d = {24'h0, 24'($urandom)};
        c = {8'h0, 8'($urandom)};
        cs_hi = 0;
        nd = 0;
        @(negedge clk);
        data_a = d[23:0]; cmd_a = c[7:0]; start_a = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 1000 && nd < 3; i++) begin
            @(negedge clk);
            if (cs_a) cs_hi++;
            if (done_a) begin
                dc[nd] = cyc;
                nd++;
            end
        end
        start_a = 1'b0;
        total++; if (nd !== 3) $display("FAIL b2b_groups got %0d want 3", nd); else passed++;
        if (nd == 3) begin
            total++; if (dc[0] - t0 !== 135) $display("FAIL b2b_first got %0d want 135", dc[0] - t0); else passed++;
            total++; if (dc[1] - dc[0] !== 135) $display("FAIL b2b_second got %0d want 135", dc[1] - dc[0]); else passed++;
            total++; if (dc[2] - dc[1] !== 135) $display("FAIL b2b_third got %0d want 135", dc[2] - dc[1]); else passed++;
        end
        total++; if (cs_hi !== 21) $display("FAIL b2b_cs_high got %0d want 21", cs_hi); else passed++;
        total++; if (qsize(0) !== 6) $display("FAIL b2b_count got %0d want 6", qsize(0)); else passed++;
        for (int k = 0; k < 6; k++) begin
            pop_word(0, w, n);
            total++; if (w !== exp_word(d, c, k % 2)) $display("FAIL b2b_word %0d got %h want %h", k, w, exp_word(d, c, k % 2)); else passed++;
        end
        repeat (2) @(negedge clk);
        total++; if (busy_a !== 1'b0) $display("FAIL b2b_stop got busy %b want 0", busy_a); else passed++;
    endtask

    task automatic test_reset_midframe();
        logic [47:0] d;
        logic [15:0] c, w;
        int lat, n;
        bit ok, b1;
        d = {24'h0, 24'($urandom)};
        c = {8'h0, 8'($urandom)};
        @(negedge clk);
        data_a = d[23:0]; cmd_a = c[7:0]; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (qsize(0) == 1 && !cs_a && nb[0] == 7) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++; if (!ok) $display("FAIL mid_reach got no ch1 bit 7 within 500 cycles"); else passed++;
        rst_a = 1'b1;
        @(negedge clk);
        total++; if ({cs_a, sclk_a, busy_a, ldac_a} !== 4'b1000) $display("FAIL mid_abort got cs/sclk/busy/ldac %b want 1000", {cs_a, sclk_a, busy_a, ldac_a}); else passed++;
        @(negedge clk);
        rst_a = 1'b0;
        q0.delete();
        d = {24'h0, 24'($urandom)};
        c = {8'h0, 8'($urandom)};
        run_grp(0, d, c, lat, ok, b1);
        total++; if (!ok || lat !== 135) $display("FAIL mid_restart_latency got %0d want 135", lat); else passed++;
        total++; if (qsize(0) !== 2) $display("FAIL mid_restart_count got %0d want 2", qsize(0)); else passed++;
        for (int ch = 0; ch < 2; ch++) begin
            pop_word(0, w, n);
            total++; if (w !== exp_word(d, c, ch) || n !== 16) $display("FAIL mid_word ch%0d got %h/%0d want %h/16", ch, w, n, exp_word(d, c, ch)); else passed++;
        end
    endtask

    task automatic test_fast();
        logic [47:0] d;
        logic [15:0] c, w;
        int lat, n;
        bit ok, b1;
        for (int k = 0; k < 2; k++) begin
            d = {16'($urandom), 32'($urandom)};
            c = 16'($urandom);
            ldac_n[1] = 0;
            run_grp(1, d, c, lat, ok, b1);
            total++; if (!ok || lat !== 133) $display("FAIL fast_latency got %0d want 133", lat); else passed++;
            total++; if (ldac_n[1] !== 0) $display("FAIL fast_ldac got %0d want 0", ldac_n[1]); else passed++;
            total++; if (qsize(1) !== 4) $display("FAIL fast_count got %0d want 4", qsize(1)); else passed++;
            for (int ch = 0; ch < 4; ch++) begin
                pop_word(1, w, n);
                total++; if (w !== exp_word(d, c, ch) || n !== 16) $display("FAIL fast_word ch%0d got %h/%0d want %h/16", ch, w, n, exp_word(d, c, ch)); else passed++;
            end
        end
    endtask

    task automatic test_auto();
        logic [47:0] d;
        logic [15:0] c, w;
        int rel, nb_seen, n;
        int beg [2];
        logic busy_l;
        d = {24'h0, 24'($urandom)};
        c = {8'h0, 8'($urandom)};
        @(negedge clk);
        data_t = d[23:0];
        cmd_t = c[7:0];
        total++; if ({cs_t, busy_t} !== 2'b10) $display("FAIL auto_reset got %b want 10", {cs_t, busy_t}); else passed++;
        rst_t = 1'b0;
        rel = cyc;
        busy_l = 1'b0;
        nb_seen = 0;
        for (int i = 0; i < 1000 && nb_seen < 2; i++) begin
            @(negedge clk);
            if (busy_t && !busy_l) begin
                beg[nb_seen] = cyc - rel + 1;
                nb_seen++;
            end
            busy_l = busy_t;
        end
        total++; if (nb_seen !== 2) $display("FAIL auto_groups got %0d want 2", nb_seen); else passed++;
        if (nb_seen == 2) begin
            total++; if (beg[0] !== 201) $display("FAIL auto_first got %0d want 201", beg[0]); else passed++;
            total++; if (beg[1] !== 401) $display("FAIL auto_second got %0d want 401", beg[1]); else passed++;
        end
        repeat (140) @(negedge clk);
        total++; if (ovr_t !== 1'b0) $display("FAIL auto_overrun got %b want 0", ovr_t); else passed++;
        total++; if (qsize(2) !== 4) $display("FAIL auto_count got %0d want 4", qsize(2)); else passed++;
        for (int k = 0; k < 4; k++) begin
            pop_word(2, w, n);
            total++; if (w !== exp_word(d, c, k % 2)) $display("FAIL auto_word %0d got %h want %h", k, w, exp_word(d, c, k % 2)); else passed++;
        end
    endtask

    task automatic test_protocol();
        for (int d = 0; d < 3; d++) begin
            total++; if (viol[d] !== 0) $display("FAIL protocol dut%0d got %0d edge violations want 0", d, viol[d]); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        test_fast();
        test_auto();
        test_protocol();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
